idu_pipe: RTL and testbench
===========================

# idu_pipe

Parametrised, buffered instruction-decode stage between the fetch unit and the execute unit. It accepts raw 32-bit RV32I/RV64I instructions with their PC over a valid/ready handshake. Each instruction is decoded as it enters: fields, instruction type, XLEN-wide immediate and an illegal flag. The decoded records go into a DEPTH-entry FIFO, which drains to execute over a second valid/ready handshake. A synchronous flush discards everything in flight on a redirect.

## Interface
- XLEN, 32, data/PC width; legal values 32 or 64.
- DEPTH, 2, number of decoded entries buffered; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered and incoming instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; equals !full.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_op  out  7  inst[6:0].
- out_funct3  out  3  inst[14:12].
- out_funct7  out  7  inst[31:25].
- out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / inst[19:15] / inst[24:20].
- out_itype  out  3  000 I, 001 U, 010 S, 011 B, 100 J, 101 R, 111 illegal.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  unsupported encoding.

## Operation
- Type from opcode, decoded at write time:
  - U: 0110111, 0010111.
  - J: 1101111.
  - I: 1100111, 0000011, 0010011, 1110011; also 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - R: 0110011; also 0111011 when XLEN=64.
  - Anything else, or inst[1:0]≠11: illegal, itype=111, illegal=1.
- Immediates are sign-extended from inst[31] to XLEN:
  - I: inst[31:20].
  - U: {inst[31:12],12'b0}, further sign-extended to XLEN.
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[7],inst[30:25],inst[11:8],0} with inst[31] as bit 12.
  - J: {inst[19:12],inst[20],inst[30:21],0} with inst[31] as bit 20.
  - R and illegal: imm=0.
- Field outputs (op, funct3, funct7, rd, rs1, rs2) are passed through raw for every type, illegal included.
- FIFO:
  - Write pointer, read pointer and occupancy count (0..DEPTH). Pointers wrap modulo DEPTH.
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
  - Push and pop in the same cycle leave the count unchanged.
  - Full: in_ready=0, so nothing is written. in_ready does not depend on out_ready.
  - Empty: out_valid=0, so no pop.
- Flush: the next edge sets count, write pointer and read pointer to 0. An instruction presented in the flush cycle is dropped, even if in_ready=1. out_valid=0 on the cycle after flush.
- All out_* data fields are forced to 0 whenever out_valid=0.
- Reset: asynchronous on rst_n low. Count, pointers and all storage clear. in_ready=1, out_valid=0, all out_* fields 0. Reset may assert mid-transfer; the state on release is identical to power-up.

## Timing
- Latency: an instruction accepted at edge N is visible at the output (out_valid=1, decoded fields) from edge N onward, i.e. in cycle N+1.
- Throughput: 1 instruction/cycle when not full and out_ready=1.
- No combinational path from in_* to out_*. in_ready and out_valid are functions of registered count only.
- Ordering is strictly FIFO.
- out_* holds stable while out_valid=1 and out_ready=0.

## Test plan
- Reset then 0xFFF00093 (addi x1,x0,-1), XLEN=32 → next cycle out_valid=1, op=0x13, rd=1, rs1=0, itype=000, imm=0xFFFFFFFF, illegal=0. Same with XLEN=64 → imm=0xFFFFFFFFFFFFFFFF.
- Stream 0x123452B7, 0x0020A423, 0xFFDFF0EF with out_ready=1 → in order:
  - lui: itype=001, rd=5, imm=0x12345000.
  - sw: itype=010, rs1=1, rs2=2, imm=8.
  - jal: itype=100, rd=1, imm=0xFFFFFFFC.
  - Throughput 1/cycle.
- out_ready=0, push DEPTH+1 instructions with PCs 0x0,0x4,… → in_ready=0 after DEPTH accepted, extra instruction held by fetch. Release out_ready → all pop in PC order with no loss or duplicate; wrap-around is exercised.
- Full FIFO with simultaneous in_valid and out_ready → one pop, no push that cycle. Next cycle in_ready=1 and the held instruction is accepted.
- Two entries buffered, flush asserted with in_valid=1 → next cycle out_valid=0, count=0, flushed instruction never appears. Also rst_n pulsed low mid-stream → immediate out_valid=0, in_ready=1.
- 0x00000000 and 0x0000007F → itype=111, illegal=1, imm=0. Opcode 0111011 → illegal when XLEN=32, itype=101 when XLEN=64.

Source files
------------

// File: rtl/idu_pipe.sv
// Instruction decode stage: decodes RV32I/RV64I words on entry
// and buffers the decoded records in a DEPTH-entry FIFO.
module idu_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_itype,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] T_I = 3'b000;
  localparam logic [2:0] T_U = 3'b001;
  localparam logic [2:0] T_S = 3'b010;
  localparam logic [2:0] T_B = 3'b011;
  localparam logic [2:0] T_J = 3'b100;
  localparam logic [2:0] T_R = 3'b101;
  localparam logic [2:0] T_X = 3'b111;

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [2:0]      itype;
    logic [XLEN-1:0] imm;
    logic            ill;
  } ent_t;

  ent_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [6:0]        op;
  logic [2:0]        dec_type;
  logic signed [31:0] imm32;
  ent_t              wr_ent;
  ent_t              head;
  logic              push, pop;

  assign op = in_inst[6:0];

  // Immediates are formed at 32 bits, then sign-extended to XLEN
  always_comb begin
    dec_type = T_X;
    imm32    = '0;
    unique case (1'b1)
      (op == 7'b0110111),
      (op == 7'b0010111): begin
        dec_type = T_U;
        imm32    = {in_inst[31:12], 12'b0};
      end
      (op == 7'b1101111): begin
        dec_type = T_J;
        imm32    = {{11{in_inst[31]}}, in_inst[31],
                    in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};
      end
      (op == 7'b1100111),
      (op == 7'b0000011),
      (op == 7'b0010011),
      (op == 7'b1110011),
      (RV64 && op == 7'b0011011): begin
        dec_type = T_I;
        imm32    = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      (op == 7'b0100011): begin
        dec_type = T_S;
        imm32    = {{20{in_inst[31]}},
                    in_inst[31:25], in_inst[11:7]};
      end
      (op == 7'b1100011): begin
        dec_type = T_B;
        imm32    = {{19{in_inst[31]}}, in_inst[31],
                    in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
      end
      (op == 7'b0110011),
      (RV64 && op == 7'b0111011): begin
        dec_type = T_R;
      end
      default: begin
        dec_type = T_X;
      end
    endcase
  end

  always_comb begin
    wr_ent       = '0;
    wr_ent.pc    = in_pc;
    wr_ent.inst  = in_inst;
    wr_ent.itype = dec_type;
    wr_ent.imm   = XLEN'(imm32);
    wr_ent.ill   = (dec_type == T_X);
  end

  assign in_ready  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push && !pop) cnt_d = cnt_q + CW'(1);
      if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= wr_ent;
    end
  end

  assign head = out_valid ? mem_q[rd_q] : '0;

  assign out_pc      = head.pc;
  assign out_op      = head.inst[6:0];
  assign out_rd      = head.inst[11:7];
  assign out_funct3  = head.inst[14:12];
  assign out_rs1     = head.inst[19:15];
  assign out_rs2     = head.inst[24:20];
  assign out_funct7  = head.inst[31:25];
  assign out_itype   = head.itype;
  assign out_imm     = head.imm;
  assign out_illegal = head.ill;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: XLEN=32 and XLEN=64 instances on one
// stimulus stream, checked against a queue-based decode model.
module tb_idu_pipe;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_pc, a_out_imm;
  logic [6:0]  a_out_op, a_out_funct7;
  logic [2:0]  a_out_funct3, a_out_itype;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_pc, b_out_imm;
  logic [6:0]  b_out_op, b_out_funct7;
  logic [2:0]  b_out_funct3, b_out_itype;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } rec_t;

  rec_t mq[$];

  idu_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_op(a_out_op),
    .out_funct3(a_out_funct3), .out_funct7(a_out_funct7),
    .out_rd(a_out_rd), .out_rs1(a_out_rs1),
    .out_rs2(a_out_rs2), .out_itype(a_out_itype),
    .out_imm(a_out_imm), .out_illegal(a_out_illegal)
  );

  idu_pipe #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_op(b_out_op),
    .out_funct3(b_out_funct3), .out_funct7(b_out_funct7),
    .out_rd(b_out_rd), .out_rs1(b_out_rs1),
    .out_rs2(b_out_rs2), .out_itype(b_out_itype),
    .out_imm(b_out_imm), .out_illegal(b_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {itype, imm(64), illegal} from the ISA rules
  function automatic logic [67:0] ref_dec(
    logic [31:0] i, int xlen);
    logic [2:0] t;
    longint     imm;
    t   = 3'd7;
    imm = 0;
    case (i[6:0])
      7'h37, 7'h17: begin
        t   = 3'd1;
        imm = longint'($signed(i[31:12])) * 4096;
      end
      7'h6F: begin
        t   = 3'd4;
        imm = longint'($signed({i[31], i[19:12], i[20],
                                i[30:21], 1'b0}));
      end
      7'h67, 7'h03, 7'h13, 7'h73: begin
        t   = 3'd0;
        imm = longint'($signed(i[31:20]));
      end
      7'h1B: if (xlen == 64) begin
        t   = 3'd0;
        imm = longint'($signed(i[31:20]));
      end
      7'h23: begin
        t   = 3'd2;
        imm = longint'($signed({i[31:25], i[11:7]}));
      end
      7'h63: begin
        t   = 3'd3;
        imm = longint'($signed({i[31], i[7], i[30:25],
                                i[11:8], 1'b0}));
      end
      7'h33: t = 3'd5;
      7'h3B: if (xlen == 64) t = 3'd5;
      default: t = 3'd7;
    endcase
    return {t, 64'(imm), (t == 3'd7)};
  endfunction

  function automatic logic [165:0] exp_vec(int xlen);
    logic [67:0] d;
    logic [63:0] pc, imm;
    logic [31:0] i;
    logic        rdy;
    if (mq.size() == 0) return {1'b0, 1'b1, 164'b0};
    i   = mq[0].inst;
    d   = ref_dec(i, xlen);
    pc  = mq[0].pc;
    imm = d[64:1];
    if (xlen == 32) begin
      pc[63:32]  = '0;
      imm[63:32] = '0;
    end
    rdy = (mq.size() < DEPTH);
    return {1'b1, rdy, pc, i[6:0], i[14:12], i[31:25],
            i[11:7], i[19:15], i[24:20], d[67:65], imm, d[0]};
  endfunction

  function automatic logic [165:0] obs32();
    return {a_out_valid, a_in_ready, 32'b0, a_out_pc,
            a_out_op, a_out_funct3, a_out_funct7, a_out_rd,
            a_out_rs1, a_out_rs2, a_out_itype, 32'b0,
            a_out_imm, a_out_illegal};
  endfunction

  function automatic logic [165:0] obs64();
    return {b_out_valid, b_in_ready, b_out_pc,
            b_out_op, b_out_funct3, b_out_funct7, b_out_rd,
            b_out_rs1, b_out_rs2, b_out_itype,
            b_out_imm, b_out_illegal};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [13];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73,
            7'h1B, 7'h23, 7'h63, 7'h33, 7'h3B, 7'h0B};
    r = $urandom();
    if ($urandom_range(0, 3) != 0)
      r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  // Advance one cycle; model applies the handshake at the edge
  task automatic step();
    bit rdy, vld;
    rdy = (mq.size() < DEPTH);
    vld = (mq.size() > 0);
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (vld && out_ready) void'(mq.pop_front());
      if (in_valid && rdy) mq.push_back('{in_inst, in_pc});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_inst = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready}
        !== 4'b0101) begin
      n_fail++;
      $display("FAIL reset_hs: got %b, expected 0101",
        {a_out_valid, a_in_ready, b_out_valid, b_in_ready});
    end
    n_checks++;
    if (obs32() !== exp_vec(32)) begin
      n_fail++;
      $display("FAIL reset32: got %h, expected %h",
        obs32(), exp_vec(32));
    end
    n_checks++;
    if (obs64() !== exp_vec(64)) begin
      n_fail++;
      $display("FAIL reset64: got %h, expected %h",
        obs64(), exp_vec(64));
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addi();
    in_valid = 1'b1;
    in_inst  = 32'hFFF00093;
    in_pc    = 64'h100;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({a_out_valid, a_out_op, a_out_rd, a_out_rs1,
         a_out_itype, a_out_illegal, a_out_imm} !==
        {1'b1, 7'h13, 5'd1, 5'd0, 3'd0, 1'b0,
         32'hFFFFFFFF}) begin
      n_fail++;
      $display("FAIL addi32: got op=%h rd=%0d it=%0d imm=%h",
        a_out_op, a_out_rd, a_out_itype, a_out_imm);
    end
    n_checks++;
    if (b_out_imm !== 64'hFFFFFFFFFFFFFFFF) begin
      n_fail++;
      $display("FAIL addi64_imm: got %h, expected all ones",
        b_out_imm);
    end
    n_checks++;
    if (obs64() !== exp_vec(64)) begin
      n_fail++;
      $display("FAIL addi64: got %h, expected %h",
        obs64(), exp_vec(64));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (obs32() !== exp_vec(32)) begin
      n_fail++;
      $display("FAIL addi_drain: got %h, expected %h",
        obs32(), exp_vec(32));
    end
  endtask

  task automatic test_stream();
    logic [31:0] insts [3];
    logic [2:0]  types [3];
    logic [31:0] imms  [3];
    insts = '{32'h123452B7, 32'h0020A423, 32'hFFDFF0EF};
    types = '{3'd1, 3'd2, 3'd4};
    imms  = '{32'h12345000, 32'h00000008, 32'hFFFFFFFC};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_inst = insts[i];
      in_pc   = 64'(i * 4);
      step();
      n_checks++;
      if ({a_out_valid, a_out_pc, a_out_itype, a_out_imm}
          !== {1'b1, 32'(i * 4), types[i], imms[i]}) begin
        n_fail++;
        $display("FAIL stream%0d: got v=%b pc=%h t=%0d imm=%h",
          i, a_out_valid, a_out_pc, a_out_itype, a_out_imm);
      end
      n_checks++;
      if (obs64() !== exp_vec(64)) begin
        n_fail++;
        $display("FAIL stream64_%0d: got %h, expected %h",
          i, obs64(), exp_vec(64));
      end
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: got %b%b, expected 00",
        a_out_valid, b_out_valid);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      in_pc   = 64'(i * 4);
      in_inst = rand_inst();
      step();
      n_checks++;
      if (obs32() !== exp_vec(32)) begin
        n_fail++;
        $display("FAIL full32_%0d: got %h, expected %h",
          i, obs32(), exp_vec(32));
      end
      if (i >= DEPTH - 1) begin
        n_checks++;
        if (a_in_ready !== 1'b0 || a_out_pc !== 32'h0) begin
          n_fail++;
          $display("FAIL full_rdy%0d: got rdy=%b pc=%h",
            i, a_in_ready, a_out_pc);
        end
      end
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if ({a_in_ready, a_out_pc} !== {1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL full_pop: got rdy=%b pc=%h, expected 1 4",
        a_in_ready, a_out_pc);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({a_out_valid, a_out_pc} !== {1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL full_held: got v=%b pc=%h, expected 1 8",
        a_out_valid, a_out_pc);
    end
    n_checks++;
    if (obs64() !== exp_vec(64)) begin
      n_fail++;
      $display("FAIL full64: got %h, expected %h",
        obs64(), exp_vec(64));
    end
    step();
    n_checks++;
    if (obs32() !== exp_vec(32)) begin
      n_fail++;
      $display("FAIL full_end: got %h, expected %h",
        obs32(), exp_vec(32));
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_inst = rand_inst();
      in_pc   = 64'(32'h40 + i * 4);
      step();
    end
    n_checks++;
    if (obs32() !== exp_vec(32)) begin
      n_fail++;
      $display("FAIL pre_flush: got %h, expected %h",
        obs32(), exp_vec(32));
    end
    flush   = 1'b1;
    in_inst = 32'h00500093;
    in_pc   = 64'h48;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready}
        !== 4'b0101) begin
      n_fail++;
      $display("FAIL flush: got %b, expected 0101",
        {a_out_valid, a_in_ready, b_out_valid, b_in_ready});
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (obs32() !== exp_vec(32) || a_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: got %h, expected %h",
        obs32(), exp_vec(32));
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00A00113;
    in_pc     = 64'h80;
    step();
    n_checks++;
    if (a_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got %b, expected 1", a_out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    n_checks++;
    if ({a_out_valid, a_in_ready, b_out_valid, b_in_ready,
         a_out_pc} !== {4'b0101, 32'h0}) begin
      n_fail++;
      $display("FAIL rmid: got %b pc=%h, expected 0101 pc=0",
        {a_out_valid, a_in_ready, b_out_valid, b_in_ready},
        a_out_pc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    n_checks++;
    if (obs64() !== exp_vec(64)) begin
      n_fail++;
      $display("FAIL rmid64: got %h, expected %h",
        obs64(), exp_vec(64));
    end
  endtask

  task automatic test_illegal();
    logic [31:0] insts [3];
    logic [2:0]  t32 [3];
    logic [2:0]  t64 [3];
    insts = '{32'h00000000, 32'h0000007F, 32'h002081BB};
    t32   = '{3'd7, 3'd7, 3'd7};
    t64   = '{3'd7, 3'd7, 3'd5};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_inst = insts[i];
      in_pc   = 64'(32'hC0 + i * 4);
      step();
      n_checks++;
      if ({a_out_itype, a_out_illegal, a_out_imm} !==
          {t32[i], 1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL ill32_%0d: got t=%0d ill=%b imm=%h",
          i, a_out_itype, a_out_illegal, a_out_imm);
      end
      n_checks++;
      if ({b_out_itype, b_out_illegal, b_out_imm} !==
          {t64[i], (t64[i] == 3'd7), 64'h0}) begin
        n_fail++;
        $display("FAIL ill64_%0d: got t=%0d ill=%b imm=%h",
          i, b_out_itype, b_out_illegal, b_out_imm);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      n_checks++;
      if (obs32() !== exp_vec(32)) begin
        n_fail++;
        $display("FAIL rand32 c%0d: got %h, expected %h",
          c, obs32(), exp_vec(32));
      end
      n_checks++;
      if (obs64() !== exp_vec(64)) begin
        n_fail++;
        $display("FAIL rand64 c%0d: got %h, expected %h",
          c, obs64(), exp_vec(64));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_inst   = rand_inst();
      in_pc     = {$urandom(), $urandom()} & ~64'h3;
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_stream();
    test_full();
    test_flush();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
